// File: rtl/mycpu_mul_seq_pkg.sv
// Shared types for the iterative multiply sequencer and the control unit that drives it.
// Optional build macro: MYCPU_MUL_EARLY_EXIT_EN (data-dependent early completion).
package mycpu_mul_seq_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

  // Control-unit wait-state code used while this block is busy
  localparam logic [3:0] CU_XM1 = 4'b1001;

endpackage

// File: rtl/mycpu_mul_seq_if.sv
// Request/response bundle between the control unit (master) and the multiply sequencer (slave).
interface mycpu_mul_seq_if #(parameter int DW = 16);
  logic          start;
  logic          abort;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          busy;
  logic          done;
  logic [DW-1:0] prod_lo;
  logic [DW-1:0] prod_hi;
  logic          z;
  logic          v;

  modport master (output start, abort, a, b,
                  input  busy, done, prod_lo, prod_hi, z, v);
  modport slave  (input  start, abort, a, b,
                  output busy, done, prod_lo, prod_hi, z, v);
endinterface

// File: rtl/mycpu_mul_seq.sv
// Shift-add DWxDW -> 2*DW unsigned multiplier, one multiplier bit per cycle.
// MYCPU_MUL_EARLY_EXIT_EN: finish once the remaining multiplier bits are all zero.
module mycpu_mul_seq
  import mycpu_mul_seq_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mycpu_mul_seq_if.slave  bus
);

  localparam int PW = 2 * DW;
  localparam int CW = $clog2(DW + 1);

  mul_state_t    state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [PW-1:0] acc_q, acc_d, acc_sum;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] prod_lo_q, prod_lo_d, prod_hi_q, prod_hi_d;
  logic          z_q, z_d, v_q, v_d;
  logic          early;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MYCPU_MUL_EARLY_EXIT_EN
  assign early = (mplier_q[DW-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    z_d       = z_q;
    v_d       = v_q;
    // abort wins over everything and leaves the result registers untouched
    if (bus.abort) begin
      state_d = MUL_IDLE;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (bus.start) begin
            mcand_d  = {{DW{1'b0}}, bus.a};
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = CW'(DW);
            state_d  = MUL_RUN;
`ifdef MYCPU_MUL_EARLY_EXIT_EN
            if (bus.b == '0) begin
              state_d   = MUL_DONE;
              prod_lo_d = '0;
              prod_hi_d = '0;
              z_d       = 1'b1;
              v_d       = 1'b0;
            end
`endif
          end
        end
        MUL_RUN: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1) || early) begin
            state_d                = MUL_DONE;
            {prod_hi_d, prod_lo_d} = acc_sum;
            z_d                    = (acc_sum == '0);
            v_d                    = (acc_sum[PW-1:DW] != '0);
          end
        end
        MUL_DONE: state_d = MUL_IDLE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MUL_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      z_q       <= z_d;
      v_q       <= v_d;
    end
  end

  assign bus.busy    = (state_q == MUL_RUN);
  assign bus.done    = (state_q == MUL_DONE);
  assign bus.prod_lo = prod_lo_q;
  assign bus.prod_hi = prod_hi_q;
  assign bus.z       = z_q;
  assign bus.v       = v_q;

endmodule

// File: tb/tb_mycpu_mul_seq.sv
// Scoreboard bench for mycpu_mul_seq (DW=16); expected latency follows MYCPU_MUL_EARLY_EXIT_EN.
module tb_mycpu_mul_seq;

  localparam int DW = 16;

  typedef struct packed {
    logic [2*DW-1:0] prod;
    logic            z;
    logic            v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [2*DW-1:0] last_prod;

  mycpu_mul_seq_if #(.DW(DW)) mif ();

  mycpu_mul_seq #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [DW-1:0] b);
    int p;
    p = DW;
`ifdef MYCPU_MUL_EARLY_EXIT_EN
    p = 0;
    for (int i = 0; i < DW; i++) if (b[i]) p = i + 1;
`endif
    return p;
  endfunction

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.prod = 32'(a) * 32'(b);
    e.z    = (e.prod == 0);
    e.v    = (e.prod[2*DW-1:DW] != 0);
    return e;
  endfunction

  // result monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (mif.done) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("prod_lo", 64'(mif.prod_lo), 64'(e.prod[DW-1:0]));
        chk("prod_hi", 64'(mif.prod_hi), 64'(e.prod[2*DW-1:DW]));
        chk("z", 64'(mif.z), 64'(e.z));
        chk("v", 64'(mif.v), 64'(e.v));
        last_prod = e.prod;
      end
    end
  end

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    mif.start = 1'b1; mif.a = a; mif.b = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 mif.start = 1'b0;
    lat = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mif.done) seen = 1;
      else if (mif.busy) lat++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(mif.done), 64'd0);
  endtask

  initial begin
    int dn_cnt, t_prev, t_now;
    mif.start = 1'b0; mif.abort = 1'b0; mif.a = '0; mif.b = '0;
    last_prod = '0;
    #12;
    chk("rst_busy", 64'(mif.busy), 64'd0);
    chk("rst_done", 64'(mif.done), 64'd0);
    chk("rst_prod", 64'({mif.prod_hi, mif.prod_lo}), 64'd0);
    chk("rst_zv", 64'({mif.z, mif.v}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'd3, 16'd5, "t1");
    run_op(16'hFFFF, 16'hFFFF, "t2");
    run_op(16'd1234, 16'd0, "t3_b0");
    run_op(16'd77, 16'd1, "t3_b1");
    for (int i = 0; i < 4; i++)
      run_op(16'($urandom), 16'($urandom), "rnd");

    // abort mid-run: no done, previous result held
    @(negedge clk);
    mif.start = 1'b1; mif.a = 16'd7; mif.b = 16'd9;
    @(posedge clk);
    #1 mif.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_busy_before_abort", 64'(mif.busy), 64'd1);
    mif.abort = 1'b1;
    @(posedge clk);
    #1 mif.abort = 1'b0;
    chk("t4_idle_after_abort", 64'(mif.busy), 64'd0);
    repeat (20) @(negedge clk);
    chk("t4_no_done", 64'(sb.size()), 64'd0);
    chk("t4_hold", 64'({mif.prod_hi, mif.prod_lo}), 64'(last_prod));
    run_op(16'd2, 16'd3, "t4_after");

    // start held high: back-to-back ops with one IDLE gap after DONE
    @(negedge clk);
    mif.start = 1'b1; mif.a = 16'd5; mif.b = 16'd6;
    for (int i = 0; i < 3; i++) sb.push_back(model(16'd5, 16'd6));
    dn_cnt = 0; t_prev = 0;
    for (int c = 0; c < 200 && dn_cnt < 3; c++) begin
      @(negedge clk);
      if (mif.done) begin
        t_now = c;
        if (dn_cnt > 0) chk("t5_period", 64'(t_now - t_prev), 64'(2 + exp_lat(16'd6)));
        t_prev = t_now;
        dn_cnt++;
        if (dn_cnt == 3) mif.start = 1'b0;
      end
    end
    chk("t5_done_count", 64'(dn_cnt), 64'd3);
    repeat (3) @(negedge clk);

    // asynchronous reset between edges while running
    @(negedge clk);
    mif.start = 1'b1; mif.a = 16'd9; mif.b = 16'hFFFF;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(mif.busy), 64'd0);
    chk("t6_done", 64'(mif.done), 64'd0);
    chk("t6_prod", 64'({mif.prod_hi, mif.prod_lo}), 64'd0);
    chk("t6_zv", 64'({mif.z, mif.v}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(16'd100, 16'd200, "t6_after");

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mycpu_mul_seq.md
Name: mycpu_mul_seq

Overview:
- Iterative shift-add multiply sequencer for MUL (FMUL) instructions.
- The control unit hands it two operands, stalls in a wait state while busy is high, and writes back the product when done pulses.
- Keeps multiplication out of the single-cycle function unit, so the combinational critical path stays within CLK_PERIOD.
- Unsigned DW×DW → 2·DW product, plus flags for the status register.

Parameters:
- DW, 16, operand width in bits. Product is 2·DW bits. Legal range 4..32.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- abort  in  1  cancel the operation in progress; highest priority.
- a  in  DW  multiplicand, captured when start is accepted.
- b  in  DW  multiplier, captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse in DONE; product and flags are valid.
- prod_lo  out  DW  low half of the product, registered.
- prod_hi  out  DW  high half of the product, registered.
- z  out  1  product == 0.
- v  out  1  prod_hi != 0 (result does not fit in DW).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = IDLE.
  - busy, done, z, v = 0.
  - prod_lo, prod_hi = 0.
  - All internal registers = 0.
- FSM states are mul_state_t: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 at edge n → mcand = zero-extended a (2·DW bits), mplier = b, acc = 0, cnt = DW.
  - Next state is RUN.
- RUN, each edge:
  - If mplier[0]=1, acc += mcand (2·DW bits, no carry out possible).
  - Then mcand <<= 1, mplier >>= 1, cnt -= 1.
  - When cnt == 1 on this edge, next state is DONE.
  - On DONE entry: prod_hi:prod_lo ← final acc; z and v are computed from the final acc.
- DONE:
  - done = 1 for exactly one cycle, then IDLE unconditionally.
  - start in DONE is ignored; the CU must reissue it in IDLE.
- Latency without the optional feature:
  - start sampled at edge n → busy high between edges n and n+DW.
  - done high between edges n+DW and n+DW+1.
- Output holding: prod_lo, prod_hi, z, v hold their value until the next DONE entry. They do not change on start or abort.
- abort:
  - Any state → IDLE at the next edge.
  - No done pulse; result registers unchanged.
  - abort together with start in IDLE: start is ignored.
- Asynchronous reset mid-RUN: immediate return to reset values. No partial result is visible.
- Boundary cases:
  - a=0 or b=0 still takes the full DW cycles; result 0, z=1.
  - All-ones operands (2^DW−1)² fit exactly in 2·DW bits; no wrap.

Optional Feature:
- Macro: MYCPU_MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, also go to DONE when the shifted mplier becomes 0.
  - In IDLE, start with b=0 goes directly to DONE, loading product 0, z=1, v=0; done is high between edges n and n+1.
  - Latency becomes the position of the highest set bit of b; busy stays high for that many cycles.
- Undefined: fixed DW-cycle latency; no data-dependent timing.
- Product value is identical in both builds.

Decomposition:
- In mycpu_pkg:
  - typedef enum logic [1:0] mul_state_t {MUL_IDLE=2'b00, MUL_RUN=2'b01, MUL_DONE=2'b10}.
  - A new cu_state_t code XM1 = 4'b1001 for the control unit's MUL wait state.
  - Opcode MUL and fs_t FMUL are already defined; the CU routes MUL to this block instead of the function unit.
- No sub-module. The add/shift datapath and FSM fit in one module.
- Test Plan, with DW=16 unless stated otherwise.

Test Plan:
1. Reset, then a=3, b=5, start pulse at edge 0 → busy high for 16 cycles, done at edge 16, prod_lo=15, prod_hi=0, z=0, v=0; without the macro, exactly one done pulse.
2. a=16'hFFFF, b=16'hFFFF → prod_hi=16'hFFFE, prod_lo=16'h0001, v=1, z=0.
3. a=1234, b=0 → prod=0, z=1. Without the macro done at edge 16; with the macro done at edge 0+1 (between edges 0 and 1). Separately, b=1 with the macro → done after one RUN edge.
4. Start a=7, b=9, assert abort at edge 5 → IDLE at edge 6, no done, outputs keep the previous result. Then start a=2, b=3 → 6 with correct latency.
5. Hold start high continuously → back-to-back operations, each accepted only in IDLE. The start seen during DONE is ignored, giving one IDLE gap cycle between operations.
6. Drop rst_n asynchronously mid-RUN (between clock edges) → busy, done, prod_lo, prod_hi, z, v clear immediately; after release, a new 100×200 multiply yields 20000.
